ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/ctrl_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control FSM for a small accumulator machine.
// It fetches an 8-bit instruction, decodes ir[7:5] as the opcode and
// ir[4:0] as a zero-extended operand, runs memory reads and writes, and
// drives the ALU/accumulator controls.
//
// Memory handshake: mem_rd or mem_wr is a request that stays asserted,
// with mem_addr (and mem_wdata for writes) stable, until the cycle in
// which mem_ack is high. That cycle completes the transfer, and read data
// is taken from mem_rdata in that same cycle. mem_ack is ignored when no
// request is outstanding.
// A request with no mem_ack after MEM_WAIT_MAX cycles moves the FSM to
// FAULT. An ack in that last cycle still completes the transfer.
// Control outputs are registered. They are decoded from the next state,
// so they line up with the state they belong to. dbg_state_o shows the
// current FSM state.
module ctrl_sequencer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  input  logic [7:0] acc,
  input  logic [7:0] alu_result,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  output logic [1:0] cntr_alu,
  output logic [7:0] alu_b,
  output logic       acc_we,
  output logic       acc_src,
  output logic [7:0] pc,
  output logic       halted,
  output logic       fault,
  output logic [2:0] dbg_state_o
);

  localparam int WW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_NAND  = 3'd1;
  localparam logic [2:0] OP_SLT   = 3'd2;
  localparam logic [2:0] OP_BZ    = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;
  localparam logic [2:0] OP_ADDI  = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMRD, S_MEMWR, S_EXEC, S_HALT, S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    pc_q, pc_d;
  logic [7:0]    ir_q, ir_d;
  logic [7:0]    opnd_q, opnd_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [WW-1:0] wait_inc;
  logic          timeout;

  logic [7:0] mem_addr_q, mem_addr_d;
  logic       mem_rd_q, mem_rd_d;
  logic       mem_wr_q, mem_wr_d;
  logic [1:0] cntr_alu_q, cntr_alu_d;
  logic       acc_we_q, acc_we_d;
  logic       acc_src_q, acc_src_d;
  logic       halted_q, halted_d;
  logic       fault_q, fault_d;

  assign wait_inc = wait_q + WW'(1);
  assign timeout  = (wait_inc == WW'(MEM_WAIT_MAX));

  // Next-state and datapath register logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    wait_d  = wait_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DECODE: begin
        wait_d = '0;
        case (ir_q[7:5])
          OP_ADD, OP_NAND, OP_SLT, OP_LOAD: state_d = S_MEMRD;
          OP_STORE:                         state_d = S_MEMWR;
          OP_ADDI, OP_BZ: begin
            opnd_d  = {3'b000, ir_q[4:0]};
            state_d = S_EXEC;
          end
          default:                          state_d = S_HALT;
        endcase
      end
      S_MEMRD: begin
        if (mem_ack) begin
          opnd_d  = mem_rdata;
          state_d = S_EXEC;
        end else if (timeout) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_MEMWR: begin
        if (mem_ack) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end else if (timeout) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_EXEC: begin
        if (ir_q[7:5] == OP_BZ && acc == 8'h00) pc_d = alu_result;
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Output decode for the state being entered; registered below.
  always_comb begin
    mem_addr_d = 8'h00;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    cntr_alu_d = 2'b00;
    acc_we_d   = 1'b0;
    acc_src_d  = 1'b0;
    halted_d   = 1'b0;
    fault_d    = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_addr_d = pc_d;
        mem_rd_d   = 1'b1;
      end
      S_MEMRD: begin
        mem_addr_d = {3'b000, ir_d[4:0]};
        mem_rd_d   = 1'b1;
      end
      S_MEMWR: begin
        mem_addr_d = {3'b000, ir_d[4:0]};
        mem_wr_d   = 1'b1;
      end
      S_EXEC: begin
        case (ir_d[7:5])
          OP_ADD, OP_ADDI: acc_we_d = 1'b1;
          OP_NAND: begin
            cntr_alu_d = 2'b01;
            acc_we_d   = 1'b1;
          end
          OP_SLT: begin
            cntr_alu_d = 2'b11;
            acc_we_d   = 1'b1;
          end
          OP_LOAD: begin
            acc_we_d  = 1'b1;
            acc_src_d = 1'b1;
          end
          OP_BZ:   cntr_alu_d = 2'b10;
          default: acc_we_d   = 1'b0;
        endcase
      end
      S_HALT:  halted_d = 1'b1;
      S_FAULT: begin
        halted_d = 1'b1;
        fault_d  = 1'b1;
      end
      default: halted_d = 1'b0;
    endcase
  end

  // State, datapath and output registers; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= 8'h00;
      ir_q       <= 8'h00;
      opnd_q     <= 8'h00;
      wait_q     <= '0;
      mem_addr_q <= 8'h00;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      cntr_alu_q <= 2'b00;
      acc_we_q   <= 1'b0;
      acc_src_q  <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      opnd_q     <= opnd_d;
      wait_q     <= wait_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      cntr_alu_q <= cntr_alu_d;
      acc_we_q   <= acc_we_d;
      acc_src_q  <= acc_src_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_wdata   = mem_wr_q ? acc : 8'h00;
  assign cntr_alu    = cntr_alu_q;
  assign alu_b       = opnd_q;
  assign acc_we      = acc_we_q;
  assign acc_src     = acc_src_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer.
// The bench has four parts. A memory model answers requests after
// ack_delay cycles. A tiny accumulator model follows acc_we and acc_src.
// Each test pushes the events it expects onto exp_q. A monitor pops the
// queue and compares on every completed memory transfer and every EXEC
// cycle.
// Event word layout: {kind[1:0], 6'b0, addr_or_ctrl[7:0], data[7:0], pc[7:0]}.
// Kind 1 is a read, 2 is a write and 3 is an EXEC cycle. For EXEC the
// ctrl byte is {4'b0, cntr_alu, acc_src, acc_we} and data is alu_b.
module tb_ctrl_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] acc;
  logic [7:0] alu_result;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [1:0] cntr_alu;
  logic [7:0] alu_b;
  logic       acc_we;
  logic       acc_src;
  logic [7:0] pc;
  logic       halted;
  logic       fault;
  logic [2:0] dbg_state_o;

  ctrl_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .acc(acc), .alu_result(alu_result), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .cntr_alu(cntr_alu), .alu_b(alu_b), .acc_we(acc_we), .acc_src(acc_src),
    .pc(pc), .halted(halted), .fault(fault), .dbg_state_o(dbg_state_o)
  );

  logic [7:0]  mem [256];
  int          ack_delay;
  bit          wr_hold;
  int          wait_cnt;
  logic [7:0]  acc_init;
  logic [31:0] exp_q[$];
  int          checks;
  int          failures;

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Memory model: decide mem_ack for each cycle just after the clock edge.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    wait_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (mem_rd || mem_wr) && !(mem_wr && wr_hold) && wait_cnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;
        if (mem_wr) mem[mem_addr] = mem_wdata;
        wait_cnt  = 0;
      end else if (rst_n && (mem_rd || mem_wr)) begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        wait_cnt++;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        wait_cnt  = 0;
      end
    end
  end

  // Accumulator model.
  always @(posedge clk) begin
    if (!rst_n) acc <= acc_init;
    else if (acc_we) acc <= acc_src ? alu_b : alu_result;
  end

  function automatic logic [31:0] mk_ev(input logic [1:0] k, input logic [7:0] a,
                                        input logic [7:0] d, input logic [7:0] p);
    return {k, 6'b0, a, d, p};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_ev(input logic [31:0] got);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event got=%h exp=none", got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL event got=%h exp=%h", got, exp);
      end
    end
  endtask

  // Scoreboard monitor: compare on every completed transfer and EXEC cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_rd && mem_wr) begin
          checks++;
          failures++;
          $display("FAIL rd_wr_exclusive got=11 exp=not both");
        end
        if ((mem_rd || mem_wr) && mem_ack)
          check_ev(mk_ev(mem_rd ? 2'd1 : 2'd2, mem_addr, mem_rd ? mem_rdata : mem_wdata, pc));
        if (acc_we || cntr_alu != 2'b00)
          check_ev(mk_ev(2'd3, {4'b0, cntr_alu, acc_src, acc_we}, alu_b, pc));
      end
    end
  end

  // Driver tasks.
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
  endtask

  task automatic run_reset(input logic [7:0] ainit);
    rst_n    = 1'b0;
    acc_init = ainit;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    bit seen;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_halted"}, halted, 1'b1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mem_rd || mem_wr) seen = 1'b1;
    end
    chk({name, "_no_req_after_stop"}, seen, 1'b0);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int rd_cycles;
    bit saw_wr;
    checks     = 0;
    failures   = 0;
    ack_delay  = 0;
    wr_hold    = 1'b0;
    alu_result = 8'h00;
    acc_init   = 8'h00;
    rst_n      = 1'b0;
    clear_mem();

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {mem_addr, mem_rd, mem_wr, mem_wdata, cntr_alu, alu_b, acc_we, acc_src, halted, fault, dbg_state_o},
        '0);
    chk("reset_pc", pc, 8'h00);

    // ADDI 5 with the fetch acked after 2 wait cycles.
    clear_mem();
    mem[8'h00] = 8'hC5;
    mem[8'h01] = 8'hE0;
    ack_delay  = 2;
    alu_result = 8'h05;
    exp_q.push_back(mk_ev(2'd1, 8'h00, 8'hC5, 8'h00));
    exp_q.push_back(mk_ev(2'd3, 8'h01, 8'h05, 8'h01));
    exp_q.push_back(mk_ev(2'd1, 8'h01, 8'hE0, 8'h01));
    run_reset(8'h00);
    @(negedge clk);
    chk("boot_idle", {mem_rd, mem_addr}, 9'h000);
    rd_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rd) rd_cycles++;
      if (mem_rd && mem_ack) break;
    end
    chk("fetch_rd_cycles", rd_cycles, 3);
    wait_done("addi", 100);
    chk("addi_final_pc", pc, 8'h02);
    chk("addi_no_fault", fault, 1'b0);

    // LOAD 0x10 then STORE 0x11.
    clear_mem();
    mem[8'h00] = 8'h90;
    mem[8'h01] = 8'hB1;
    mem[8'h02] = 8'hE0;
    mem[8'h10] = 8'h7F;
    ack_delay  = 1;
    exp_q.push_back(mk_ev(2'd1, 8'h00, 8'h90, 8'h00));
    exp_q.push_back(mk_ev(2'd1, 8'h10, 8'h7F, 8'h01));
    exp_q.push_back(mk_ev(2'd3, 8'h03, 8'h7F, 8'h01));
    exp_q.push_back(mk_ev(2'd1, 8'h01, 8'hB1, 8'h01));
    exp_q.push_back(mk_ev(2'd2, 8'h11, 8'h7F, 8'h02));
    exp_q.push_back(mk_ev(2'd1, 8'h02, 8'hE0, 8'h02));
    run_reset(8'h00);
    wait_done("ldst", 200);
    chk("ldst_mem_written", mem[8'h11], 8'h7F);

    // ADD, NAND, SLT with memory operands.
    clear_mem();
    mem[8'h00] = 8'h05;
    mem[8'h01] = 8'h26;
    mem[8'h02] = 8'h47;
    mem[8'h03] = 8'hE0;
    mem[8'h05] = 8'h22;
    mem[8'h06] = 8'h33;
    mem[8'h07] = 8'h44;
    ack_delay  = 0;
    alu_result = 8'h00;
    exp_q.push_back(mk_ev(2'd1, 8'h00, 8'h05, 8'h00));
    exp_q.push_back(mk_ev(2'd1, 8'h05, 8'h22, 8'h01));
    exp_q.push_back(mk_ev(2'd3, 8'h01, 8'h22, 8'h01));
    exp_q.push_back(mk_ev(2'd1, 8'h01, 8'h26, 8'h01));
    exp_q.push_back(mk_ev(2'd1, 8'h06, 8'h33, 8'h02));
    exp_q.push_back(mk_ev(2'd3, 8'h05, 8'h33, 8'h02));
    exp_q.push_back(mk_ev(2'd1, 8'h02, 8'h47, 8'h02));
    exp_q.push_back(mk_ev(2'd1, 8'h07, 8'h44, 8'h03));
    exp_q.push_back(mk_ev(2'd3, 8'h0D, 8'h44, 8'h03));
    exp_q.push_back(mk_ev(2'd1, 8'h03, 8'hE0, 8'h03));
    run_reset(8'h00);
    wait_done("alu_ops", 200);
    chk("alu_ops_final_pc", pc, 8'h04);

    // BZ 0x08 taken (acc == 0).
    clear_mem();
    mem[8'h00] = 8'h68;
    mem[8'h08] = 8'hE0;
    alu_result = 8'h08;
    exp_q.push_back(mk_ev(2'd1, 8'h00, 8'h68, 8'h00));
    exp_q.push_back(mk_ev(2'd3, 8'h08, 8'h08, 8'h01));
    exp_q.push_back(mk_ev(2'd1, 8'h08, 8'hE0, 8'h08));
    run_reset(8'h00);
    wait_done("bz_taken", 100);
    chk("bz_taken_final_pc", pc, 8'h09);

    // BZ 0x08 not taken (acc == 3).
    clear_mem();
    mem[8'h00] = 8'h68;
    mem[8'h01] = 8'hE0;
    alu_result = 8'h01;
    exp_q.push_back(mk_ev(2'd1, 8'h00, 8'h68, 8'h00));
    exp_q.push_back(mk_ev(2'd3, 8'h08, 8'h08, 8'h01));
    exp_q.push_back(mk_ev(2'd1, 8'h01, 8'hE0, 8'h01));
    run_reset(8'h03);
    wait_done("bz_not_taken", 100);
    chk("bz_not_taken_final_pc", pc, 8'h02);

    // Branch to 0xFF, fetch HALT there; pc wraps to 0x00.
    clear_mem();
    mem[8'h00] = 8'h68;
    mem[8'hFF] = 8'hE0;
    alu_result = 8'hFF;
    exp_q.push_back(mk_ev(2'd1, 8'h00, 8'h68, 8'h00));
    exp_q.push_back(mk_ev(2'd3, 8'h08, 8'h08, 8'h01));
    exp_q.push_back(mk_ev(2'd1, 8'hFF, 8'hE0, 8'hFF));
    run_reset(8'h00);
    wait_done("pc_wrap", 100);
    chk("pc_wrap_pc", pc, 8'h00);

    // No ack in FETCH: fault after 15 request cycles.
    clear_mem();
    ack_delay = 1000;
    run_reset(8'h00);
    rd_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fault) break;
      if (mem_rd) rd_cycles++;
    end
    chk("timeout_rd_cycles", rd_cycles, 15);
    chk("timeout_flags", {fault, halted, mem_rd}, 3'b110);
    repeat (4) @(negedge clk);
    chk("timeout_terminal", {fault, halted, mem_rd, mem_wr}, 4'b1100);
    chk("timeout_no_events", exp_q.size(), 0);

    // Ack in the 15th request cycle completes the fetch.
    clear_mem();
    ack_delay = 14;
    exp_q.push_back(mk_ev(2'd1, 8'h00, 8'hE0, 8'h00));
    run_reset(8'h00);
    wait_done("ack_at_limit", 60);
    chk("ack_at_limit_no_fault", fault, 1'b0);

    // Reset pulse while a STORE waits in MEMWR.
    clear_mem();
    mem[8'h00] = 8'hB1;
    mem[8'h01] = 8'hE0;
    ack_delay  = 0;
    wr_hold    = 1'b1;
    exp_q.push_back(mk_ev(2'd1, 8'h00, 8'hB1, 8'h00));
    run_reset(8'h00);
    saw_wr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_wr) begin
        saw_wr = 1'b1;
        break;
      end
    end
    chk("memwr_reached", saw_wr, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_drops_wr", {mem_wr, mem_rd, mem_addr, pc}, 18'h0);
    exp_q.delete();
    wr_hold = 1'b0;
    exp_q.push_back(mk_ev(2'd1, 8'h00, 8'hB1, 8'h00));
    exp_q.push_back(mk_ev(2'd2, 8'h11, 8'h00, 8'h01));
    exp_q.push_back(mk_ev(2'd1, 8'h01, 8'hE0, 8'h01));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reboot_boot_idle", {mem_rd, mem_wr}, 2'b00);
    @(negedge clk);
    chk("reboot_fetch_addr0", {mem_rd, mem_addr}, 9'h100);
    wait_done("reboot", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
